// File: rtl/mem_loader_ctrl_if.sv
// Host-side streams of mem_loader_ctrl: s_* carries command/data words in, m_* carries
// readback (and optional checksum) words out. Both use a valid/ready handshake.
interface mem_loader_ctrl_if;
   logic        s_valid;
   logic        s_ready;
   logic [15:0] s_data;
   logic        m_valid;
   logic        m_ready;
   logic [15:0] m_data;

   modport master (output s_valid, s_data, m_ready, input s_ready, m_valid, m_data);
   modport slave  (input s_valid, s_data, m_ready, output s_ready, m_valid, m_data);
endinterface

// File: rtl/mem_loader_ctrl.sv
// Host command sequencer driving top_control's external memory port (load / run / readback).
// Optional feature macro LOADER_CHECKSUM_EN: emit a 16-bit data sum after each load command.
module mem_loader_ctrl #(
   parameter int unsigned SETUP_CYC = 2,
   parameter int unsigned WE_CYC    = 4,
   parameter int unsigned HOLD_CYC  = 4,
   parameter int unsigned RD_CYC    = 5,
   parameter int unsigned RUN_SHIFT = 8
) (
   input  logic               clock,
   input  logic               reset_n,
   mem_loader_ctrl_if.slave   host,
   output logic [8:0]         addr_ext,
   output logic [15:0]        Data_in_ins,
   output logic [15:0]        Data_in_dram,
   output logic               iram_write_ext,
   output logic               dram_write_ext,
   output logic               read_en_ext,
   input  logic [15:0]        dram_in,
   output logic               start,
   output logic               start_2,
   output logic               start_3,
   output logic               start_4,
   output logic               busy,
   output logic               err
);

   localparam int unsigned RUN_W = 9 + RUN_SHIFT;

   typedef enum logic [1:0] {
      CMD_LD_IRAM = 2'b00,
      CMD_LD_DRAM = 2'b01,
      CMD_RUN     = 2'b10,
      CMD_RB      = 2'b11
   } cmd_t;

   typedef enum logic [3:0] {
      IDLE, HDR2, LD_WAIT, SETUP, WE, HOLD, RUN, RB_RD, RB_OUT
`ifdef LOADER_CHECKSUM_EN
      , CK_OUT
`endif
   } state_t;

   state_t           state;
   cmd_t             cmd;
   logic [8:0]       count;
   logic [7:0]       tmr;
   logic [RUN_W-1:0] run_tmr;
`ifdef LOADER_CHECKSUM_EN
   logic [15:0]      sum;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         cmd            <= CMD_LD_IRAM;
         count          <= '0;
         tmr            <= '0;
         run_tmr        <= '0;
         host.s_ready   <= 1'b1;
         host.m_valid   <= 1'b0;
         host.m_data    <= '0;
         addr_ext       <= '0;
         Data_in_ins    <= '0;
         Data_in_dram   <= '0;
         iram_write_ext <= 1'b0;
         dram_write_ext <= 1'b0;
         read_en_ext    <= 1'b0;
         start          <= 1'b0;
         start_2        <= 1'b0;
         start_3        <= 1'b0;
         start_4        <= 1'b0;
         busy           <= 1'b0;
         err            <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         sum            <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (host.s_valid) begin
                  cmd      <= cmd_t'(host.s_data[15:14]);
                  addr_ext <= host.s_data[8:0];
                  if (host.s_data[15:14] != 2'b10 && host.s_data[13:9] != 5'd0) err <= 1'b1;
                  start_2  <= (host.s_data[15:14] == 2'b00);
                  start_3  <= (host.s_data[15:14] == 2'b01);
                  start_4  <= (host.s_data[15:14] == 2'b11);
                  busy     <= 1'b1;
                  state    <= HDR2;
               end
            end
            HDR2: begin
               if (host.s_valid) begin
                  count <= host.s_data[8:0];
`ifdef LOADER_CHECKSUM_EN
                  sum   <= '0;
`endif
                  if (host.s_data[8:0] == 9'd0) begin
                     start_2 <= 1'b0;
                     start_3 <= 1'b0;
                     start_4 <= 1'b0;
                     busy    <= 1'b0;
                     state   <= IDLE;
                  end else begin
                     case (cmd)
                        CMD_RUN: begin
                           host.s_ready <= 1'b0;
                           start        <= 1'b1;
                           run_tmr      <= (RUN_W'(host.s_data[8:0]) << RUN_SHIFT) - RUN_W'(1);
                           state        <= RUN;
                        end
                        CMD_RB: begin
                           host.s_ready <= 1'b0;
                           read_en_ext  <= 1'b1;
                           tmr          <= 8'(RD_CYC - 1);
                           state        <= RB_RD;
                        end
                        default: state <= LD_WAIT;
                     endcase
                  end
               end
            end
            LD_WAIT: begin
               if (host.s_valid) begin
                  host.s_ready <= 1'b0;
                  if (cmd == CMD_LD_IRAM) Data_in_ins  <= host.s_data;
                  else                    Data_in_dram <= host.s_data;
`ifdef LOADER_CHECKSUM_EN
                  sum <= sum + host.s_data;
`endif
                  tmr   <= 8'(SETUP_CYC - 1);
                  state <= SETUP;
               end
            end
            SETUP: begin
               if (tmr == 8'd0) begin
                  if (cmd == CMD_LD_IRAM) iram_write_ext <= 1'b1;
                  else                    dram_write_ext <= 1'b1;
                  tmr   <= 8'(WE_CYC - 1);
                  state <= WE;
               end else begin
                  tmr <= tmr - 8'd1;
               end
            end
            WE: begin
               if (tmr == 8'd0) begin
                  iram_write_ext <= 1'b0;
                  dram_write_ext <= 1'b0;
                  tmr            <= 8'(HOLD_CYC - 1);
                  state          <= HOLD;
               end else begin
                  tmr <= tmr - 8'd1;
               end
            end
            HOLD: begin
               if (tmr == 8'd0) begin
                  // Address advances after every word; wrapping past 511 flags err but continues.
                  if (addr_ext == 9'h1FF) err <= 1'b1;
                  addr_ext <= addr_ext + 9'd1;
                  count    <= count - 9'd1;
                  if (count == 9'd1) begin
`ifdef LOADER_CHECKSUM_EN
                     host.m_data  <= sum;
                     host.m_valid <= 1'b1;
                     state        <= CK_OUT;
`else
                     host.s_ready <= 1'b1;
                     start_2      <= 1'b0;
                     start_3      <= 1'b0;
                     busy         <= 1'b0;
                     state        <= IDLE;
`endif
                  end else begin
                     host.s_ready <= 1'b1;
                     state        <= LD_WAIT;
                  end
               end else begin
                  tmr <= tmr - 8'd1;
               end
            end
            RUN: begin
               if (run_tmr == '0) begin
                  start        <= 1'b0;
                  host.s_ready <= 1'b1;
                  busy         <= 1'b0;
                  state        <= IDLE;
               end else begin
                  run_tmr <= run_tmr - RUN_W'(1);
               end
            end
            RB_RD: begin
               if (tmr == 8'd0) begin
                  host.m_data  <= dram_in;
                  host.m_valid <= 1'b1;
                  read_en_ext  <= 1'b0;
                  state        <= RB_OUT;
               end else begin
                  tmr <= tmr - 8'd1;
               end
            end
            RB_OUT: begin
               if (host.m_ready) begin
                  host.m_valid <= 1'b0;
                  if (addr_ext == 9'h1FF) err <= 1'b1;
                  addr_ext <= addr_ext + 9'd1;
                  count    <= count - 9'd1;
                  if (count == 9'd1) begin
                     host.s_ready <= 1'b1;
                     start_4      <= 1'b0;
                     busy         <= 1'b0;
                     state        <= IDLE;
                  end else begin
                     read_en_ext <= 1'b1;
                     tmr         <= 8'(RD_CYC - 1);
                     state       <= RB_RD;
                  end
               end
            end
`ifdef LOADER_CHECKSUM_EN
            CK_OUT: begin
               if (host.m_ready) begin
                  host.m_valid <= 1'b0;
                  host.s_ready <= 1'b1;
                  start_2      <= 1'b0;
                  start_3      <= 1'b0;
                  busy         <= 1'b0;
                  state        <= IDLE;
               end
            end
`endif
            default: begin
               host.s_ready <= 1'b1;
               busy         <= 1'b0;
               state        <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_loader_ctrl.sv
// Directed bench for mem_loader_ctrl: table of load/readback commands plus hand-written
// sequences for reset mid-strobe, RUN length and readback backpressure.
module tb_mem_loader_ctrl;

   localparam logic [1:0] C_IRAM = 2'b00, C_DRAM = 2'b01, C_RUN = 2'b10, C_RB = 2'b11;

   typedef struct {
      logic [1:0]  cmd;
      logic [4:0]  extra;
      logic [8:0]  base;
      logic [8:0]  cnt;
      logic [15:0] d[3];
      logic [8:0]  ea[3];
      logic [15:0] ed[3];
      logic [15:0] esum;
      logic        eerr;
   } vec_t;

   typedef struct {
      logic [8:0]  a;
      logic [15:0] d;
      int unsigned len;
      logic        mode;
   } pulse_t;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [8:0]  addr_ext;
   logic [15:0] Data_in_ins, Data_in_dram, dram_in;
   logic        iram_write_ext, dram_write_ext, read_en_ext;
   logic        start, start_2, start_3, start_4, busy, err;

   mem_loader_ctrl_if ifc ();

   mem_loader_ctrl dut (
      .clock(clock), .reset_n(reset_n), .host(ifc),
      .addr_ext(addr_ext), .Data_in_ins(Data_in_ins), .Data_in_dram(Data_in_dram),
      .iram_write_ext(iram_write_ext), .dram_write_ext(dram_write_ext),
      .read_en_ext(read_en_ext), .dram_in(dram_in),
      .start(start), .start_2(start_2), .start_3(start_3), .start_4(start_4),
      .busy(busy), .err(err)
   );

   always #5 clock = ~clock;

   // DRAM stand-in: unwritten locations read as 0x5A00 + address.
   logic [15:0] dram_mem [512];
   bit   [511:0] dram_wr;
   always @(posedge clock) begin
      if (dram_write_ext) begin
         dram_mem[addr_ext] <= Data_in_dram;
         dram_wr[addr_ext]  <= 1'b1;
      end
   end
   assign dram_in = dram_wr[addr_ext] ? dram_mem[addr_ext] : (16'h5A00 + {7'd0, addr_ext});

   int unsigned n_chk = 0, n_fail = 0;
   vec_t        vt[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic pulse_t mk(input logic [8:0] a, input logic [15:0] d,
                                 input int unsigned len, input logic mode);
      pulse_t p;
      p.a = a; p.d = d; p.len = len; p.mode = mode;
      return p;
   endfunction

   // Pulse monitors
   pulse_t      iw_q[$], dw_q[$], rd_q[$];
   logic [15:0] m_q[$];
   int unsigned iw_len, dw_len, rd_len, gi, gd;
   logic [8:0]  iw_a, dw_a, rd_a;
   logic [15:0] iw_d, dw_d;
   logic        iw_m, dw_m;

   always @(negedge clock) begin
      if (iram_write_ext) begin
         if (iw_len != 0 && (addr_ext != iw_a || Data_in_ins != iw_d)) gi <= gi + 1;
         iw_len <= iw_len + 1; iw_a <= addr_ext; iw_d <= Data_in_ins; iw_m <= start_2;
      end else if (iw_len != 0) begin
         iw_q.push_back(mk(iw_a, iw_d, iw_len, iw_m));
         iw_len <= 0;
      end
   end

   always @(negedge clock) begin
      if (dram_write_ext) begin
         if (dw_len != 0 && (addr_ext != dw_a || Data_in_dram != dw_d)) gd <= gd + 1;
         dw_len <= dw_len + 1; dw_a <= addr_ext; dw_d <= Data_in_dram; dw_m <= start_3;
      end else if (dw_len != 0) begin
         dw_q.push_back(mk(dw_a, dw_d, dw_len, dw_m));
         dw_len <= 0;
      end
   end

   always @(negedge clock) begin
      if (read_en_ext) begin
         rd_len <= rd_len + 1; rd_a <= addr_ext;
      end else if (rd_len != 0) begin
         rd_q.push_back(mk(rd_a, 16'h0, rd_len, 1'b0));
         rd_len <= 0;
      end
      if (ifc.m_valid && ifc.m_ready) m_q.push_back(ifc.m_data);
   end

   task automatic apply_reset();
      @(negedge clock);
      ifc.s_valid = 1'b0;
      reset_n     = 1'b0;
      repeat (2) @(negedge clock);
      #1 reset_n = 1'b1;
   endtask

   task automatic send_word(input logic [15:0] w);
      int unsigned t = 0;
      @(negedge clock);
      ifc.s_valid = 1'b1;
      ifc.s_data  = w;
      while (!ifc.s_ready && t < 3000) begin
         @(negedge clock);
         t++;
      end
      check("s_ready_accept", {31'd0, ifc.s_ready}, 32'd1);
      @(posedge clock);
      #1 ifc.s_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int unsigned t = 0;
      @(negedge clock);
      while (busy && t < 3000) begin
         @(negedge clock);
         t++;
      end
      check("busy_clears", {31'd0, busy}, 32'd0);
   endtask

   task automatic run_vec(input int unsigned k);
      vec_t        v;
      pulse_t      wq[$];
      int unsigned iw0, dw0, rd0, m0, wbase;
      v = vt[k];
      apply_reset();
      iw0 = iw_q.size(); dw0 = dw_q.size(); rd0 = rd_q.size(); m0 = m_q.size();
      send_word({v.cmd, v.extra, v.base});
      send_word({7'd0, v.cnt});
      if (v.cmd == C_IRAM || v.cmd == C_DRAM)
         for (int i = 0; i < int'(v.cnt); i++) send_word(v.d[i]);
      wait_idle();
      if (v.cmd == C_IRAM || v.cmd == C_DRAM) begin
         if (v.cmd == C_IRAM) begin
            wq = iw_q; wbase = iw0;
            check($sformatf("v%0d_other_wr", k), dw_q.size() - dw0, 0);
            check($sformatf("v%0d_dram_bus_held", k), {16'd0, Data_in_dram}, 32'd0);
         end else begin
            wq = dw_q; wbase = dw0;
            check($sformatf("v%0d_other_wr", k), iw_q.size() - iw0, 0);
            check($sformatf("v%0d_ins_bus_held", k), {16'd0, Data_in_ins}, 32'd0);
         end
         check($sformatf("v%0d_wr_count", k), wq.size() - wbase, {23'd0, v.cnt});
         for (int i = 0; i < int'(v.cnt); i++) begin
            if (wbase + i < wq.size()) begin
               check($sformatf("v%0d_wr%0d_addr", k, i), {23'd0, wq[wbase+i].a}, {23'd0, v.ea[i]});
               check($sformatf("v%0d_wr%0d_data", k, i), {16'd0, wq[wbase+i].d}, {16'd0, v.ed[i]});
               check($sformatf("v%0d_wr%0d_len", k, i), wq[wbase+i].len, 32'd4);
               check($sformatf("v%0d_wr%0d_mode", k, i), {31'd0, wq[wbase+i].mode}, 32'd1);
            end
         end
`ifdef LOADER_CHECKSUM_EN
         check($sformatf("v%0d_cksum_count", k), m_q.size() - m0, (v.cnt != 0) ? 32'd1 : 32'd0);
         if (v.cnt != 0 && m0 < m_q.size())
            check($sformatf("v%0d_cksum", k), {16'd0, m_q[m0]}, {16'd0, v.esum});
`else
         check($sformatf("v%0d_no_mvalid", k), m_q.size() - m0, 32'd0);
`endif
      end else begin
         check($sformatf("v%0d_no_writes", k), (iw_q.size() - iw0) + (dw_q.size() - dw0), 32'd0);
         check($sformatf("v%0d_rd_count", k), rd_q.size() - rd0, {23'd0, v.cnt});
         check($sformatf("v%0d_m_count", k), m_q.size() - m0, {23'd0, v.cnt});
         for (int i = 0; i < int'(v.cnt); i++) begin
            if (rd0 + i < rd_q.size()) begin
               check($sformatf("v%0d_rd%0d_addr", k, i), {23'd0, rd_q[rd0+i].a}, {23'd0, v.ea[i]});
               check($sformatf("v%0d_rd%0d_len", k, i), rd_q[rd0+i].len, 32'd5);
            end
            if (m0 + i < m_q.size())
               check($sformatf("v%0d_m%0d_data", k, i), {16'd0, m_q[m0+i]}, {16'd0, v.ed[i]});
         end
      end
      check($sformatf("v%0d_err", k), {31'd0, err}, {31'd0, v.eerr});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int unsigned n, viol, unst, r0, m0;
      logic [15:0] d0;
      reset_n = 1'b0; ifc.s_valid = 1'b0; ifc.s_data = '0; ifc.m_ready = 1'b1;

      //         cmd     extra  base     cnt    data                            exp addr                    exp data                        sum       err
      vt[0] = '{C_IRAM, 5'd0, 9'd1,   9'd3, '{16'd10, 16'd20, 16'd30},       '{9'd1, 9'd2, 9'd3},        '{16'd10, 16'd20, 16'd30},       16'h003C, 1'b0};
      vt[1] = '{C_DRAM, 5'd0, 9'h1FF, 9'd2, '{16'h1234, 16'h5678, 16'h0},    '{9'h1FF, 9'h000, 9'h0},    '{16'h1234, 16'h5678, 16'h0},    16'h68AC, 1'b1};
      vt[2] = '{C_DRAM, 5'd1, 9'h040, 9'd1, '{16'hBEEF, 16'h0, 16'h0},       '{9'h040, 9'h0, 9'h0},      '{16'hBEEF, 16'h0, 16'h0},       16'hBEEF, 1'b1};
      vt[3] = '{C_IRAM, 5'd0, 9'd7,   9'd0, '{16'h0, 16'h0, 16'h0},          '{9'h0, 9'h0, 9'h0},        '{16'h0, 16'h0, 16'h0},          16'h0000, 1'b0};
      vt[4] = '{C_RB,   5'd0, 9'h040, 9'd2, '{16'h0, 16'h0, 16'h0},          '{9'h040, 9'h041, 9'h0},    '{16'hBEEF, 16'h5A41, 16'h0},    16'h0000, 1'b0};
      vt[5] = '{C_RB,   5'd0, 9'h000, 9'd2, '{16'h0, 16'h0, 16'h0},          '{9'h000, 9'h001, 9'h0},    '{16'h5678, 16'h5A01, 16'h0},    16'h0000, 1'b0};
      vt[6] = '{C_RB,   5'd0, 9'h1FF, 9'd2, '{16'h0, 16'h0, 16'h0},          '{9'h1FF, 9'h000, 9'h0},    '{16'h1234, 16'h5678, 16'h0},    16'h0000, 1'b1};
      vt[7] = '{C_DRAM, 5'd0, 9'h010, 9'd2, '{16'hFFFF, 16'h0002, 16'h0},    '{9'h010, 9'h011, 9'h0},    '{16'hFFFF, 16'h0002, 16'h0},    16'h0001, 1'b0};
      vt[8] = '{C_RB,   5'd3, 9'h010, 9'd1, '{16'h0, 16'h0, 16'h0},          '{9'h010, 9'h0, 9'h0},      '{16'hFFFF, 16'h0, 16'h0},       16'h0000, 1'b1};

      // Reset state, sampled while reset is held
      repeat (2) @(negedge clock);
      check("rst_strobes", {22'd0, iram_write_ext, dram_write_ext, read_en_ext, start, start_2,
                            start_3, start_4, ifc.m_valid, busy, err}, 32'd0);
      check("rst_s_ready", {31'd0, ifc.s_ready}, 32'd1);
      check("rst_addr", {23'd0, addr_ext}, 32'd0);
      apply_reset();

      // Reset in the middle of an IRAM write strobe
      send_word({C_IRAM, 5'd0, 9'd4});
      send_word(16'd1);
      send_word(16'hAAAA);
      @(negedge clock); check("setup_c1", {31'd0, iram_write_ext}, 32'd0);
      @(negedge clock); check("setup_c2", {31'd0, iram_write_ext}, 32'd0);
      @(negedge clock); check("we_c3", {31'd0, iram_write_ext}, 32'd1);
      check("we_addr_data", {7'd0, addr_ext, Data_in_ins}, {7'd0, 9'd4, 16'hAAAA});
      check("we_start_2", {31'd0, start_2}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_drop", {29'd0, iram_write_ext, start_2, busy}, 32'd0);
      check("async_rst_ready", {31'd0, ifc.s_ready}, 32'd1);

      for (int unsigned k = 0; k < 9; k++) run_vec(k);

      // RUN count 2 (extra header bits must not raise err on RUN)
      apply_reset();
      send_word({C_RUN, 5'h1F, 9'd0});
      send_word(16'd2);
      n = 0; viol = 0;
      @(negedge clock);
      while (start && n < 2000) begin
         if (start_2 || start_3 || start_4) viol++;
         n++;
         @(negedge clock);
      end
      check("run_len", n, 32'd512);
      check("run_mode_sel", viol, 32'd0);
      check("run_err", {31'd0, err}, 32'd0);
      check("run_busy_done", {31'd0, busy}, 32'd0);

      // RUN count 0: no pulse
      send_word({C_RUN, 5'd0, 9'd0});
      send_word(16'd0);
      n = 0;
      repeat (4) begin
         @(negedge clock);
         if (start) n++;
      end
      check("run0_no_pulse", n, 32'd0);
      check("run0_idle", {31'd0, busy}, 32'd0);

      // Readback with backpressure
      apply_reset();
      ifc.m_ready = 1'b0;
      r0 = rd_q.size(); m0 = m_q.size();
      send_word({C_RB, 5'd0, 9'd5});
      send_word(16'd2);
      n = 0;
      @(negedge clock);
      while (!ifc.m_valid && n < 100) begin
         @(negedge clock);
         n++;
      end
      check("rb_first_valid", {31'd0, ifc.m_valid}, 32'd1);
      d0 = ifc.m_data;
      check("rb_first_data", {16'd0, d0}, 32'h5A05);
      unst = 0;
      repeat (7) begin
         @(negedge clock);
         if (!ifc.m_valid || ifc.m_data != d0 || read_en_ext) unst++;
      end
      check("rb_stall_stable", unst, 32'd0);
      @(posedge clock);
      #1 ifc.m_ready = 1'b1;
      wait_idle();
      check("rb_bp_m_count", m_q.size() - m0, 32'd2);
      if (m0 + 1 < m_q.size()) begin
         check("rb_bp_word0", {16'd0, m_q[m0]}, 32'h5A05);
         check("rb_bp_word1", {16'd0, m_q[m0+1]}, 32'h5A06);
      end
      check("rb_bp_rd_count", rd_q.size() - r0, 32'd2);
      if (r0 + 1 < rd_q.size()) begin
         check("rb_bp_rd0_len", rd_q[r0].len, 32'd5);
         check("rb_bp_rd1_len", rd_q[r0+1].len, 32'd5);
      end

      check("wr_bus_stable", gi + gd, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
